// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the instruction-memory loader and
// the instruction memory.
//   WORD_BYTES        bytes per instruction word (byte address = index*4)
//   MAX_WORDS_DEFAULT program length limit, also the instruction-memory depth
//   loaderState_t     loader FSM states; VRD/VCMP exist only when
//                     INSTR_LOADER_VERIFY_EN is defined
package mips_pkg;

  localparam int WORD_BYTES        = 4;
  localparam int WORD_SHIFT        = $clog2(WORD_BYTES);
  localparam int MAX_WORDS_DEFAULT = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RELEASE,
    RUN
`ifdef INSTR_LOADER_VERIFY_EN
    , VRD,
    VCMP
`endif
  } loaderState_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: host word stream plus instruction-memory port.
//   in_valid/in_data/in_last  host -> loader word stream
//   in_ready                  loader -> host, word taken this cycle
//   mem_addr/mem_wdata/mem_we loader -> memory write port
//   mem_re/mem_rdata          readback port (rdata valid the cycle after re)
// Modports: master = loader side, slave = host/memory side.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 32
) ();
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;

  modport master (
    input  in_valid, in_data, in_last, mem_rdata,
    output in_ready, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    output in_valid, in_data, in_last, mem_rdata,
    input  in_ready, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/instr_mem_loader_counter.sv
// load_index_counter: word index and written-word count for the loader.
//   clk, rst_n  clock, async active-low reset
//   clr         zero both registers (new load)
//   incIdx      advance index to the next word slot
//   incCnt      count one written word
//   index       current word index
//   wordCount   words written in the current/last load
//   lastIdx     index sits on the final permitted slot (MAX_WORDS-1)
module load_index_counter #(
  parameter int MAX_WORDS = 256,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             incIdx,
  input  logic             incCnt,
  output logic [IDX_W-1:0] index,
  output logic [IDX_W:0]   wordCount,
  output logic             lastIdx
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index     <= '0;
      wordCount <= '0;
    end else if (clr) begin
      index     <= '0;
      wordCount <= '0;
    end else begin
      if (incIdx) index <= index + IDX_W'(1);
      if (incCnt) wordCount <= wordCount + (IDX_W + 1)'(1);
    end
  end

  assign lastIdx = (index == IDX_W'(MAX_WORDS - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams instruction words from a host into consecutive
// instruction-memory words, holding the processor in initialisation until
// the load ends, then releasing the PC and pipeline.
// Optional readback check: define INSTR_LOADER_VERIFY_EN.
//   clk, rst_n    clock, async active-low reset
//   start         pulse: begin (IDLE) or restart (RUN) a load
//   bus           host stream + memory port (instr_mem_loader_if.master)
//   initializing  memory address mux on the loader
//   pc_reset      hold PC at 0
//   done          program loaded, processor running
//   error         sticky readback mismatch (0 without the verify option)
//   word_count    words written in the current/last load
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT,
  parameter int IDX_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_mem_loader_if.master  bus,
  output logic                initializing,
  output logic                pc_reset,
  output logic                done,
  output logic                error,
  output logic [IDX_W:0]      word_count
);

  loaderState_t      state, stateNext;
  logic              clr, incIdx, incCnt;
  logic [IDX_W-1:0]  index;
  logic              lastIdx;
  logic [31:0]       dataQ;
  logic [ADDR_W-1:0] addrQ;
  logic              lastQ;
  logic              accept;
  logic              loadEnd;

  load_index_counter #(
    .MAX_WORDS(MAX_WORDS),
    .IDX_W    (IDX_W)
  ) idxCnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .incIdx   (incIdx),
    .incCnt   (incCnt),
    .index    (index),
    .wordCount(word_count),
    .lastIdx  (lastIdx)
  );

  assign accept  = (state == LOAD) && bus.in_valid;
  // Either the host flags the end or the last memory slot has been written.
  assign loadEnd = lastQ || lastIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    clr       = 1'b0;
    incIdx    = 1'b0;
    incCnt    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = LOAD;
          clr       = 1'b1;
        end
      end
      LOAD: begin
        if (bus.in_valid) stateNext = WRITE;
      end
      WRITE: begin
        incCnt = 1'b1;
`ifdef INSTR_LOADER_VERIFY_EN
        stateNext = VRD;
`else
        if (loadEnd) begin
          stateNext = RELEASE;
        end else begin
          stateNext = LOAD;
          incIdx    = 1'b1;
        end
`endif
      end
`ifdef INSTR_LOADER_VERIFY_EN
      VRD: stateNext = VCMP;
      VCMP: begin
        if (loadEnd) begin
          stateNext = RELEASE;
        end else begin
          stateNext = LOAD;
          incIdx    = 1'b1;
        end
      end
`endif
      RELEASE: stateNext = RUN;
      RUN: begin
        if (start) begin
          stateNext = LOAD;
          clr       = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Word, address and end flag are captured at acceptance so the write
  // (and any readback) sees stable values while the host moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataQ <= '0;
      addrQ <= '0;
      lastQ <= 1'b0;
    end else if (accept) begin
      dataQ <= bus.in_data;
      addrQ <= ADDR_W'(index) << WORD_SHIFT;
      lastQ <= bus.in_last;
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_addr  = addrQ;
  assign bus.mem_wdata = dataQ;
  // PC reset is held through RELEASE so the PC captures 0 while the memory
  // already looks at the PC address.
  assign initializing  = !((state == RELEASE) || (state == RUN));
  assign pc_reset      = (state != RUN);
  assign done          = (state == RUN);

`ifdef INSTR_LOADER_VERIFY_EN
  logic errorQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          errorQ <= 1'b0;
    else if (clr)                                        errorQ <= 1'b0;
    else if ((state == VCMP) && (bus.mem_rdata != dataQ)) errorQ <= 1'b1;
  end

  assign bus.mem_re = (state == VRD);
  assign error      = errorQ;
`else
  logic unusedRdata;
  assign unusedRdata = ^bus.mem_rdata;
  assign bus.mem_re  = 1'b0;
  assign error       = 1'b0;
`endif

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Sequential program loader sitting directly upstream of the processor's instruction memory and PC.
- Accepts a stream of 32-bit instruction words from a host (testbench or serial front-end) over a valid/ready handshake.
- Writes each word to consecutive word addresses and holds the processor in initialisation (PC reset, instruction-address mux on the loader) until the load completes.
- Then releases the pipeline to run.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- MAX_WORDS, 256, maximum program length in words; the final permitted word ends the load.
- IDX_W, 8, width of the word index/counter; must satisfy 2**IDX_W >= MAX_WORDS.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: begin or restart a load.
- in_valid  in  1  host word valid.
- in_data  in  32  instruction word.
- in_last  in  1  qualifies final word of the program.
- in_ready  out  1  loader accepts a word this cycle.
- mem_addr  out  ADDR_W  instruction-memory byte address = index*4.
- mem_wdata  out  32  word to write.
- mem_we  out  1  write strobe, one cycle per word.
- mem_re  out  1  read strobe; used only by the verify feature, otherwise 0.
- mem_rdata  in  32  instruction-memory read data, valid the cycle after mem_re.
- initializing  out  1  selects loader address onto the instruction memory.
- pc_reset  out  1  holds PC at 0.
- done  out  1  program loaded; processor running.
- error  out  1  sticky readback mismatch; verify feature only, otherwise 0.
- word_count  out  IDX_W+1  words written in the current or last load.

Behaviour:
- Reset values: state IDLE, in_ready=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, initializing=1, pc_reset=1, done=0, error=0, word_count=0.
- States: IDLE, LOAD, WRITE, RELEASE, RUN; VRD and VCMP are added with the optional feature.
- IDLE: waits for start, then goes to LOAD with index=0, word_count=0 and error cleared.
- LOAD: in_ready=1. A word is accepted on in_valid&in_ready. On acceptance, register data, address (index<<2) and the last flag, then go to WRITE.
- WRITE: in_ready=0, mem_we=1 for exactly this cycle, word_count increments at the end of this cycle.
  - If the feature is enabled, go to VRD.
  - Otherwise, if last_q or index==MAX_WORDS-1, go to RELEASE.
  - Otherwise increment index and go to LOAD.
- Throughput: 1 word per 2 cycles (per 4 with verify). Write latency from acceptance is 1 cycle.
- RELEASE (1 cycle): initializing=0, pc_reset=1, so the PC captures 0 with the memory switched to the PC address. Then go to RUN.
- RUN: initializing=0, pc_reset=0, done=1.
  - start in RUN returns to LOAD: done=0, initializing=1, pc_reset=1, index=0, word_count=0, error cleared.
- start in LOAD/WRITE/VRD/VCMP/RELEASE is ignored.
- Overflow: the word at index MAX_WORDS-1 ends the load even when in_last=0. No word is accepted beyond it, because in_ready stays 0 in RELEASE/RUN.
- in_valid outside LOAD is not consumed; the host must hold data stable until in_ready.
- Async reset mid-load:
  - All state and outputs return to their reset values immediately.
  - Memory holds the partial program.
  - A new start is required.
- mem_addr wraps modulo 2**ADDR_W. This is unreachable with legal parameters.

Optional Feature:
- Macro: INSTR_LOADER_VERIFY_EN.
- Defined:
  - WRITE goes to VRD.
  - VRD: mem_re=1 at the same address.
  - VCMP: compare mem_rdata with the registered word; a mismatch sets error (sticky until the next start/reset).
  - Then apply the WRITE termination rules, so throughput is 1 word per 4 cycles.
  - The load always completes; error does not block release.
- Not defined: VRD/VCMP do not exist, mem_re is tied 0, error is tied 0.

Decomposition:
- Shared package mips_pkg holds:
  - the loader state enum;
  - WORD_BYTES=4;
  - the default MAX_WORDS constant, shared with the instruction-memory depth.
- One natural sub-module, load_index_counter: index/word_count register with clear, increment and terminal-count flag (index==MAX_WORDS-1).

Test Plan:
- Reset then start; stream 7 words back-to-back with in_last on the 7th:
  - Words: 20110005, 20100002, 2012fffd, ac000005, 00009820, 00119842, 02304822.
  - Writes occur at addresses 0,4,...,24 on cycles 2,4,...,14 after start.
  - RELEASE on cycle 15; done=1 on cycle 16; word_count=7.
- Host inserts random in_valid gaps:
  - Identical memory image to the back-to-back run.
  - No word is duplicated or dropped.
  - mem_we pulses exactly 7 times.
- MAX_WORDS=4 with in_last never asserted:
  - Load ends after the 4th word (address 12).
  - in_ready=0 afterwards.
  - A 5th word is never accepted; done=1.
- Assert rst_n low after 3 words:
  - Outputs return to reset values immediately.
  - A restart reloads from address 0.
- start pulse in RUN:
  - done=0 and pc_reset=1 on the next cycle.
  - Reload of 2 words succeeds; word_count=2.
- With INSTR_LOADER_VERIFY_EN: force mem_rdata bit 0 flipped on word 3:
  - error=1 from VCMP of that word and stays 1.
  - done still asserts.
  - Error clears on the next start.
